// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider sequencing controller.
package div_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWait,
    StResp,
    StDrain
  } state_e;

  // req_op bit positions
  localparam int unsigned OP_MOD = 0;
  localparam int unsigned OP_UNS = 1;

  // dout_tdata layout: {quotient, remainder}
  localparam int unsigned QUOT_HI = 63;
  localparam int unsigned QUOT_LO = 32;
  localparam int unsigned REM_HI  = 31;
  localparam int unsigned REM_LO  = 0;

  function automatic logic [31:0] pick_result(input logic [63:0] dout, input logic is_mod);
    return is_mod ? dout[REM_HI:REM_LO] : dout[QUOT_HI:QUOT_LO];
  endfunction

endpackage

// File: rtl/div_chan_issue.sv
// Holds one AXI-Stream input channel's tvalid from issue until its handshake or an abort.
module div_chan_issue (
  input  logic clk,
  input  logic resetn,
  input  logic issue,
  input  logic abort,
  input  logic tready,
  output logic tvalid,
  output logic done
);

  logic valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (abort) begin
      valid_d = 1'b0;
    end else if (issue) begin
      valid_d = 1'b1;
    end else if (valid_q && tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign tvalid = valid_q;
  // Already handshaken, or handshaking in this cycle.
  assign done   = ~valid_q | tready;

endmodule

// File: rtl/div_ctrl.sv
// Sequences one div/mod request through the signed or unsigned divider IP and returns the result.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        busy,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        err,
  output logic [31:0] dividend_tdata,
  output logic [31:0] divisor_tdata,
  output logic        dividend_tvalid_s,
  output logic        divisor_tvalid_s,
  output logic        dividend_tvalid_u,
  output logic        divisor_tvalid_u,
  input  logic        dividend_tready_s,
  input  logic        divisor_tready_s,
  input  logic        dividend_tready_u,
  input  logic        divisor_tready_u,
  input  logic        dout_tvalid_s,
  input  logic        dout_tvalid_u,
  input  logic [63:0] dout_tdata_s,
  input  logic [63:0] dout_tdata_u
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [1:0]        op_q;
  logic [31:0]       dvd_q, dvs_q, res_q;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              err_q;

  logic              uns, issue, abort, capture, timeout;
  logic              sel_dout;
  logic [63:0]       sel_tdata;
  logic              dvd_tready, dvs_tready, dvd_tvalid, dvs_tvalid, dvd_done, dvs_done;

  assign uns        = op_q[OP_UNS];
  assign issue      = (state_q == StIdle) && req_valid && !flush;
  assign sel_dout   = uns ? dout_tvalid_u : dout_tvalid_s;
  assign sel_tdata  = uns ? dout_tdata_u : dout_tdata_s;
  assign dvd_tready = uns ? dividend_tready_u : dividend_tready_s;
  assign dvs_tready = uns ? divisor_tready_u : divisor_tready_s;
  assign cnt_inc    = cnt_q + CntW'(1);
  assign timeout    = ((state_q == StWait) || (state_q == StDrain)) && (cnt_inc == CntW'(TIMEOUT));

  div_chan_issue u_dvd_chan (
    .clk    (clk),
    .resetn (resetn),
    .issue  (issue),
    .abort  (abort),
    .tready (dvd_tready),
    .tvalid (dvd_tvalid),
    .done   (dvd_done)
  );

  div_chan_issue u_dvs_chan (
    .clk    (clk),
    .resetn (resetn),
    .issue  (issue),
    .abort  (abort),
    .tready (dvs_tready),
    .tvalid (dvs_tvalid),
    .done   (dvs_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (issue) state_d = StSend;
      end
      StSend: begin
        if (flush) begin
          state_d = StDrain;
        end else if (dvd_done && dvs_done) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (sel_dout) begin
          // A result landing together with flush is simply dropped.
          if (flush) begin
            state_d = StIdle;
          end else begin
            state_d = StResp;
            capture = 1'b1;
          end
        end else if (timeout) begin
          abort   = 1'b1;
          state_d = StIdle;
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      StDrain: begin
        if (sel_dout && dvd_done && dvs_done) begin
          state_d = StIdle;
        end else if (timeout) begin
          abort   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (issue || (state_q == StSend && state_d == StWait)) begin
      cnt_d = '0;
    end else if (state_q == StWait || state_q == StDrain) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q  <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | abort;
      if (issue) begin
        op_q  <= req_op;
        dvd_q <= req_src1;
        dvs_q <= req_src2;
      end
      if (capture) begin
        res_q <= pick_result(sel_tdata, op_q[OP_MOD]);
      end
    end
  end

  always_comb begin
    req_ready         = (state_q == StIdle);
    busy              = (state_q != StIdle);
    res_valid         = (state_q == StResp) && !flush;
    res_data          = res_q;
    err               = err_q;
    dividend_tdata    = dvd_q;
    divisor_tdata     = dvs_q;
    dividend_tvalid_s = dvd_tvalid && !uns;
    divisor_tvalid_s  = dvs_tvalid && !uns;
    dividend_tvalid_u = dvd_tvalid && uns;
    divisor_tvalid_u  = dvs_tvalid && uns;
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: table of full transactions plus hand-written flush/timeout/reset cases.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid, req_ready, flush, busy, res_valid, err;
  logic [1:0]  req_op;
  logic [31:0] req_src1, req_src2, res_data, dividend_tdata, divisor_tdata;
  logic        dividend_tvalid_s, divisor_tvalid_s, dividend_tvalid_u, divisor_tvalid_u;
  logic        dividend_tready_s, divisor_tready_s, dividend_tready_u, divisor_tready_u;
  logic        dout_tvalid_s, dout_tvalid_u;
  logic [63:0] dout_tdata_s, dout_tdata_u;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pulses = 0;
  int   p0;

  localparam logic [63:0] Garbage = 64'hBAD0_0BAD_DEAD_BEEF;

  always #5 clk = ~clk;

  always @(negedge clk) if (res_valid === 1'b1) pulses <= pulses + 1;

  div_ctrl #(.TIMEOUT(64)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_op            (req_op),
    .req_src1          (req_src1),
    .req_src2          (req_src2),
    .flush             (flush),
    .busy              (busy),
    .res_valid         (res_valid),
    .res_data          (res_data),
    .err               (err),
    .dividend_tdata    (dividend_tdata),
    .divisor_tdata     (divisor_tdata),
    .dividend_tvalid_s (dividend_tvalid_s),
    .divisor_tvalid_s  (divisor_tvalid_s),
    .dividend_tvalid_u (dividend_tvalid_u),
    .divisor_tvalid_u  (divisor_tvalid_u),
    .dividend_tready_s (dividend_tready_s),
    .divisor_tready_s  (divisor_tready_s),
    .dividend_tready_u (dividend_tready_u),
    .divisor_tready_u  (divisor_tready_u),
    .dout_tvalid_s     (dout_tvalid_s),
    .dout_tvalid_u     (dout_tvalid_u),
    .dout_tdata_s      (dout_tdata_s),
    .dout_tdata_u      (dout_tdata_u)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, " tvalids"}, {dividend_tvalid_s, divisor_tvalid_s, dividend_tvalid_u,
                           divisor_tvalid_u}, 4'b0000);
    chk({nm, " busy"}, busy, 1'b0);
    chk({nm, " req_ready"}, req_ready, 1'b1);
    chk({nm, " res_valid"}, res_valid, 1'b0);
  endtask

  // Full transaction with all treadys high and a short IP latency.
  task automatic txn(input vec_t v, input string nm);
    logic uns;
    int   pb;
    uns = v.op[1];
    pb  = pulses;
    if (uns) begin
      dout_tdata_u = {v.q, v.r};
      dout_tdata_s = Garbage;
    end else begin
      dout_tdata_s = {v.q, v.r};
      dout_tdata_u = Garbage;
    end
    req_valid = 1'b1;
    req_op    = v.op;
    req_src1  = v.a;
    req_src2  = v.b;
    #1 chk({nm, " req_ready"}, req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
    #1;
    chk({nm, " sel valids"}, uns ? {dividend_tvalid_u, divisor_tvalid_u}
                                 : {dividend_tvalid_s, divisor_tvalid_s}, 2'b11);
    chk({nm, " unsel valids"}, uns ? {dividend_tvalid_s, divisor_tvalid_s}
                                   : {dividend_tvalid_u, divisor_tvalid_u}, 2'b00);
    chk({nm, " tdata"}, {dividend_tdata, divisor_tdata}, {v.a, v.b});
    cyc();
    #1 chk({nm, " wait valids"}, {dividend_tvalid_s, divisor_tvalid_s, dividend_tvalid_u,
                                  divisor_tvalid_u}, 4'b0000);
    // Stray result from the other IP must be ignored.
    if (uns) dout_tvalid_s = 1'b1;
    else dout_tvalid_u = 1'b1;
    cyc();
    dout_tvalid_s = 1'b0;
    dout_tvalid_u = 1'b0;
    #1 chk({nm, " busy in wait"}, busy, 1'b1);
    cyc();
    if (uns) dout_tvalid_u = 1'b1;
    else dout_tvalid_s = 1'b1;
    cyc();
    dout_tvalid_s = 1'b0;
    dout_tvalid_u = 1'b0;
    #1;
    chk({nm, " res_valid"}, res_valid, 1'b1);
    chk({nm, " res_data"}, res_data, v.exp);
    cyc();
    #1;
    chk({nm, " busy after"}, busy, 1'b0);
    chk({nm, " pulses"}, pulses - pb, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0;
    req_op = 2'b00;
    req_src1 = '0;
    req_src2 = '0;
    flush = 1'b0;
    dividend_tready_s = 1'b1;
    divisor_tready_s = 1'b1;
    dividend_tready_u = 1'b1;
    divisor_tready_u = 1'b1;
    dout_tvalid_s = 1'b0;
    dout_tvalid_u = 1'b0;
    dout_tdata_s = Garbage;
    dout_tdata_u = Garbage;

    //          op     src1           src2    quotient       remainder      expected
    vecs[0] = '{2'b10, 32'd100,       32'd7,  32'd14,        32'd2,         32'd14};
    vecs[1] = '{2'b01, 32'hFFFFFFF9,  32'd2,  32'hFFFFFFFD,  32'hFFFFFFFF,  32'hFFFFFFFF};
    vecs[2] = '{2'b00, 32'hFFFFFFF9,  32'd2,  32'hFFFFFFFD,  32'hFFFFFFFF,  32'hFFFFFFFD};
    vecs[3] = '{2'b11, 32'd100,       32'd7,  32'd14,        32'd2,         32'd2};
    vecs[4] = '{2'b10, 32'd5,         32'd0,  32'hFFFFFFFF,  32'd5,         32'hFFFFFFFF};
    vecs[5] = '{2'b11, 32'd20,        32'd3,  32'd6,         32'd2,         32'd2};

    #12;
    chk_idle_outputs("reset");
    chk("reset err", err, 1'b0);
    chk("reset res_data", res_data, 32'd0);
    chk("reset tdata", {dividend_tdata, divisor_tdata}, 64'd0);
    resetn = 1'b1;
    cyc();

    // flush with req_valid in IDLE: nothing accepted
    req_valid = 1'b1;
    flush = 1'b1;
    req_op = 2'b10;
    cyc();
    req_valid = 1'b0;
    flush = 1'b0;
    #1 chk_idle_outputs("idle flush");

    for (int i = 0; i < 6; i++) txn(vecs[i], $sformatf("vec%0d", i));

    // Signed remainder with dividend tready low for 3 cycles
    dividend_tready_s = 1'b0;
    dout_tdata_s = {32'hFFFFFFFD, 32'hFFFFFFFF};
    start_req(2'b01, 32'hFFFFFFF9, 32'd2);
    #1 chk("stall both valid", {dividend_tvalid_s, divisor_tvalid_s}, 2'b11);
    cyc();
    #1 chk("stall divisor drop", {dividend_tvalid_s, divisor_tvalid_s}, 2'b10);
    cyc();
    #1 chk("stall dvd held 2", dividend_tvalid_s, 1'b1);
    cyc();
    dividend_tready_s = 1'b1;
    #1 chk("stall dvd held 3", dividend_tvalid_s, 1'b1);
    cyc();
    #1 chk("stall dvd done", {dividend_tvalid_s, busy}, 2'b01);
    cyc();
    cyc();
    dout_tvalid_s = 1'b1;
    cyc();
    dout_tvalid_s = 1'b0;
    #1 chk("stall result", {res_valid, res_data}, {1'b1, 32'hFFFFFFFF});
    cyc();
    #1 chk("stall idle", busy, 1'b0);

    // Flush in WAIT, then back-to-back request
    p0 = pulses;
    dout_tdata_u = {32'd10, 32'd0};
    start_req(2'b10, 32'd50, 32'd5);
    cyc();
    cyc();
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1 chk("wflush drain busy", busy, 1'b1);
    cyc();
    cyc();
    dout_tvalid_u = 1'b1;
    #1 chk("wflush busy before dout", busy, 1'b1);
    cyc();
    dout_tvalid_u = 1'b0;
    #1;
    chk("wflush idle", {busy, res_valid}, 2'b00);
    chk("wflush no pulse", pulses - p0, 0);
    chk("wflush res_data held", res_data, 32'hFFFFFFFF);
    vecs[5].op = 2'b10;
    vecs[5].exp = 32'd6;
    txn(vecs[5], "b2b");

    // Flush in SEND with divisor tready low for 4 cycles
    p0 = pulses;
    divisor_tready_u = 1'b0;
    dout_tdata_u = {32'd3, 32'd0};
    start_req(2'b10, 32'd9, 32'd3);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1 chk("sflush valids", {dividend_tvalid_u, divisor_tvalid_u, busy}, 3'b011);
    cyc();
    cyc();
    #1 chk("sflush divisor held", divisor_tvalid_u, 1'b1);
    cyc();
    divisor_tready_u = 1'b1;
    cyc();
    #1 chk("sflush divisor done", {divisor_tvalid_u, busy}, 2'b01);
    cyc();
    dout_tvalid_u = 1'b1;
    #1 chk("sflush busy before dout", busy, 1'b1);
    cyc();
    dout_tvalid_u = 1'b0;
    #1;
    chk_idle_outputs("sflush end");
    chk("sflush no pulse", pulses - p0, 0);

    // Flush in RESP suppresses the pulse
    p0 = pulses;
    dout_tdata_s = {32'd5, 32'd1};
    start_req(2'b00, 32'd11, 32'd2);
    cyc();
    dout_tvalid_s = 1'b1;
    cyc();
    dout_tvalid_s = 1'b0;
    flush = 1'b1;
    #1 chk("rflush res_valid", res_valid, 1'b0);
    cyc();
    flush = 1'b0;
    #1 chk("rflush idle", {busy, 32'(pulses - p0)}, 33'd0);

    // Flush together with dout in WAIT returns straight to IDLE
    start_req(2'b00, 32'd11, 32'd2);
    cyc();
    flush = 1'b1;
    dout_tvalid_s = 1'b1;
    cyc();
    flush = 1'b0;
    dout_tvalid_s = 1'b0;
    #1 chk_idle_outputs("wflush+dout");

    // Timeout: no dout ever arrives
    p0 = pulses;
    start_req(2'b00, 32'd1, 32'd1);
    cyc();
    #1 chk("to in wait", {busy, err}, 2'b10);
    repeat (63) cyc();
    #1 chk("to before limit", {busy, err}, 2'b10);
    cyc();
    #1;
    chk("to err", err, 1'b1);
    chk_idle_outputs("to");
    chk("to no pulse", pulses - p0, 0);
    cyc();
    #1 chk("to err sticky", err, 1'b1);

    // Async reset mid-WAIT
    p0 = pulses;
    dout_tdata_u = {32'd14, 32'd2};
    start_req(2'b10, 32'd100, 32'd7);
    cyc();
    cyc();
    resetn = 1'b0;
    #1;
    chk_idle_outputs("rst mid");
    chk("rst mid err", err, 1'b0);
    chk("rst mid res_data", res_data, 32'd0);
    chk("rst mid tdata", {dividend_tdata, divisor_tdata}, 64'd0);
    cyc();
    resetn = 1'b1;
    cyc();
    dout_tvalid_u = 1'b1;
    cyc();
    dout_tvalid_u = 1'b0;
    #1;
    chk_idle_outputs("rst stale dout");
    chk("rst stale no pulse", {res_data, 32'(pulses - p0)}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
